// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU stage: opcodes, FSM encoding and
// the default datapath width.
package alu_pkg;

   localparam int ALU_WIDTH = 8;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SHL = 3'b101,
      OP_MUL = 3'b110,
      OP_DIV = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_ITER = 2'd2,
      S_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/alu_iter.sv
// Iterative datapath shared by MUL (right-shifting shift-add) and DIV
// (left-shifting restoring division), one bit per step.
module alu_iter
   import alu_pkg::*;
#(
   parameter  int WIDTH = ALU_WIDTH,
   parameter  int ITER  = WIDTH,
   localparam int CW    = $clog2(ITER + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_load,
   input  logic             i_is_div,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_step,
   output logic [CW-1:0]    o_count,
   output logic [WIDTH-1:0] o_result,
   output logic             o_hi_nz
);

   // r_hi/r_lo form the {product high, product low} pair for MUL and the
   // {remainder, quotient} pair for DIV.
   logic             r_is_div;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_opb;

   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_rem_sh;
   logic [WIDTH:0]   w_rem_sub;
   logic             w_ge;

   always_comb begin
      w_sum     = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_opb : '0)};
      w_rem_sh  = {r_hi, r_lo[WIDTH-1]};
      w_rem_sub = w_rem_sh - {1'b0, r_opb};
      w_ge      = (w_rem_sh >= {1'b0, r_opb});
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_is_div <= 1'b0;
         r_count  <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_opb    <= '0;
      end else if (i_load) begin
         r_is_div <= i_is_div;
         r_count  <= '0;
         r_hi     <= '0;
         r_lo     <= i_a;
         r_opb    <= i_b;
      end else if (i_step) begin
         r_count <= r_count + 1'b1;
         if (r_is_div) begin
            r_hi <= w_ge ? w_rem_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], w_ge};
         end else begin
            r_hi <= w_sum[WIDTH:1];
            r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
         end
      end
   end

   assign o_count  = r_count;
   assign o_result = r_lo;
   assign o_hi_nz  = |r_hi;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU stage feeding the accumulator: single-cycle logic/add/sub,
// iterative MUL/DIV, start/busy handshake and a one-cycle done pulse.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int ITER  = WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic             ovf,
   output logic             err
);

   localparam int CW = $clog2(ITER + 1);

   state_e           r_state;
   state_e           w_next_state;
   op_e              r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_result;
   logic             r_carry;
   logic             r_zero;
   logic             r_ovf;
   logic             r_err;

   logic             w_accept;
   logic             w_to_iter;
   logic             w_finish_iter;
   logic             w_step;
   logic             w_update;
   logic [CW-1:0]    w_count;
   logic [WIDTH-1:0] w_iter_res;
   logic             w_iter_hi_nz;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_diff;
   logic [WIDTH-1:0] w_res;
   logic             w_carry;
   logic             w_ovf;
   logic             w_err;

   // A new request is taken in IDLE and also in DONE, giving back-to-back ops.
   assign w_accept      = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_to_iter     = (op_e'(op) == OP_MUL) || ((op_e'(op) == OP_DIV) && (b != '0));
   assign w_finish_iter = (r_state == S_ITER) && (w_count == CW'(ITER));
   assign w_step        = (r_state == S_ITER) && !w_finish_iter;
   assign w_update      = (r_state == S_EXEC) || w_finish_iter;

   alu_iter #(.WIDTH(WIDTH), .ITER(ITER)) u_iter (
      .clock    (clock),
      .reset    (reset),
      .i_load   (w_accept && w_to_iter),
      .i_is_div (op_e'(op) == OP_DIV),
      .i_a      (a),
      .i_b      (b),
      .i_step   (w_step),
      .o_count  (w_count),
      .o_result (w_iter_res),
      .o_hi_nz  (w_iter_hi_nz)
   );

   // NOTE: every combinational output gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE, S_DONE: w_next_state = w_accept ? (w_to_iter ? S_ITER : S_EXEC) : S_IDLE;
         S_EXEC:         w_next_state = S_DONE;
         S_ITER:         w_next_state = w_finish_iter ? S_DONE : S_ITER;
         default:        w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      w_sum   = {1'b0, r_a} + {1'b0, r_b};
      w_diff  = {1'b0, r_a} - {1'b0, r_b};
      w_res   = '0;
      w_carry = 1'b0;
      w_ovf   = 1'b0;
      w_err   = 1'b0;
      if (r_state == S_ITER) begin
         w_res = w_iter_res;
         w_ovf = (r_op == OP_MUL) && w_iter_hi_nz;
      end else begin
         case (r_op)
            OP_ADD: begin
               w_res   = w_sum[WIDTH-1:0];
               w_carry = w_sum[WIDTH];
               w_ovf   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_SUB: begin
               w_res   = w_diff[WIDTH-1:0];
               w_carry = w_diff[WIDTH];
               w_ovf   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_AND: w_res = r_a & r_b;
            OP_OR:  w_res = r_a | r_b;
            OP_XOR: w_res = r_a ^ r_b;
            OP_SHL: begin
               w_res   = {r_a[WIDTH-2:0], 1'b0};
               w_carry = r_a[WIDTH-1];
            end
            // Only a zero divisor reaches EXEC with DIV.
            OP_DIV: begin
               w_res = '1;
               w_err = 1'b1;
            end
            default: w_res = '0;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_op     <= OP_ADD;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_carry  <= 1'b0;
         r_zero   <= 1'b0;
         r_ovf    <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_op <= op_e'(op);
            r_a  <= a;
            r_b  <= b;
         end
         if (w_update) begin
            r_result <= w_res;
            r_carry  <= w_carry;
            r_zero   <= (w_res == '0);
            r_ovf    <= w_ovf;
            r_err    <= w_err;
         end
      end
   end

   assign busy   = (r_state == S_EXEC) || (r_state == S_ITER);
   assign done   = (r_state == S_DONE);
   assign result = r_result;
   assign carry  = r_carry;
   assign zero   = r_zero;
   assign ovf    = r_ovf;
   assign err    = r_err;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: table of hand-computed vectors plus sequences for
// ignored starts, back-to-back ops, result hold and mid-operation reset.
module tb_alu_seq;
   import alu_pkg::*;

   localparam int W = 8;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [2:0]   op    = 3'b000;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         busy, done, carry, zero, ovf, err;
   logic [W-1:0] result;

   int n_checks = 0;
   int n_errors = 0;

   alu_seq #(.WIDTH(W), .ITER(W)) dut (
      .clock  (clock),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .carry  (carry),
      .zero   (zero),
      .ovf    (ovf),
      .err    (err)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         c;
      logic         z;
      logic         v;
      logic         e;
      int           lat;
   } vec_t;

   vec_t vecs [17];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Drive a request #1 after a clock edge; returns #1 after the accepting edge.
   task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
   endtask

   // Counts edges until done is seen; -1 if the bound expires.
   task automatic wait_done(output int lat);
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clock);
         #1;
         if (done) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic check_outs(input string tag, input logic [W-1:0] r,
                             input logic c, input logic z, input logic v, input logic e);
      check({tag, "_result"}, int'(result), int'(r));
      check({tag, "_carry"},  int'(carry),  int'(c));
      check({tag, "_zero"},   int'(zero),   int'(z));
      check({tag, "_ovf"},    int'(ovf),    int'(v));
      check({tag, "_err"},    int'(err),    int'(e));
   endtask

   initial begin
      int lat;
      int done_seen;

      vecs[0]  = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1};
      vecs[1]  = '{OP_SUB, 8'h05, 8'h06, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1};
      vecs[2]  = '{OP_SUB, 8'h33, 8'h33, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1};
      vecs[3]  = '{OP_MUL, 8'h10, 8'h11, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0, 9};
      vecs[4]  = '{OP_MUL, 8'h0C, 8'h0A, 8'h78, 1'b0, 1'b0, 1'b0, 1'b0, 9};
      vecs[5]  = '{OP_DIV, 8'd200, 8'd7, 8'd28, 1'b0, 1'b0, 1'b0, 1'b0, 9};
      vecs[6]  = '{OP_DIV, 8'h05, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1};
      vecs[7]  = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1};
      vecs[8]  = '{OP_OR,  8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1};
      vecs[9]  = '{OP_XOR, 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1};
      vecs[10] = '{OP_SHL, 8'h81, 8'h55, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1};
      vecs[11] = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1};
      vecs[12] = '{OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0, 1};
      vecs[13] = '{OP_MUL, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 9};
      vecs[14] = '{OP_DIV, 8'hFF, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 9};
      vecs[15] = '{OP_DIV, 8'h03, 8'h09, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 9};
      vecs[16] = '{OP_MUL, 8'h00, 8'h37, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 9};

      // Reset state while reset is held.
      #3;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check_outs("rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      #9;
      reset = 1'b0;
      @(posedge clock);
      #1;

      for (int i = 0; i < 17; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b);
         check($sformatf("v%0d_busy", i), int'(busy), 1);
         wait_done(lat);
         check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
         check_outs($sformatf("v%0d", i), vecs[i].res, vecs[i].c, vecs[i].z, vecs[i].v, vecs[i].e);
         @(posedge clock);
         #1;
         check($sformatf("v%0d_done_pulse", i), int'(done), 0);
         check($sformatf("v%0d_idle_busy", i), int'(busy), 0);
      end

      // start pulses during MUL busy are ignored.
      issue(OP_MUL, 8'h10, 8'h11);
      @(posedge clock);
      #1;
      op    = OP_ADD;
      a     = 8'h01;
      b     = 8'h01;
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      @(posedge clock);
      #1;
      check("ign_busy", int'(busy), 1);
      wait_done(lat);
      check("ign_latency", lat, 6);
      check_outs("ign", 8'h10, 1'b0, 1'b0, 1'b1, 1'b0);
      @(posedge clock);
      #1;
      check("ign_no_queue_done", int'(done), 0);
      check("ign_no_queue_busy", int'(busy), 0);

      // Back-to-back: start accepted in the DONE cycle.
      issue(OP_ADD, 8'h01, 8'h02);
      wait_done(lat);
      check("b2b_first_latency", lat, 1);
      check("b2b_first_result", int'(result), 8'h03);
      issue(OP_SUB, 8'h09, 8'h04);
      check("b2b_second_busy", int'(busy), 1);
      check("b2b_second_done", int'(done), 0);
      wait_done(lat);
      check("b2b_second_latency", lat, 1);
      check_outs("b2b", 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);

      // Result and flags hold while inputs move without start.
      op = OP_XOR;
      a  = 8'h77;
      b  = 8'h77;
      repeat (3) @(posedge clock);
      #1;
      check_outs("hold", 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset at iteration 4 of a DIV aborts with no done pulse.
      issue(OP_DIV, 8'd200, 8'd7);
      repeat (4) @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_done", int'(done), 0);
      check_outs("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      done_seen = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clock);
         #1;
         if (done) done_seen++;
      end
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clock);
         #1;
         if (done) done_seen++;
      end
      check("mid_rst_no_done", done_seen, 0);

      issue(OP_ADD, 8'h20, 8'h22);
      wait_done(lat);
      check("post_rst_add_latency", lat, 1);
      check_outs("post_rst_add", 8'h42, 1'b0, 1'b0, 1'b0, 1'b0);
      issue(OP_DIV, 8'd200, 8'd7);
      wait_done(lat);
      check("post_rst_div_latency", lat, 9);
      check_outs("post_rst_div", 8'd28, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
